reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one W-bit storage register among N requesters using round-robin write arbitration.
- Optional multi-cycle ownership is available via lock.
- Sits in front of the 32-bit register datapath. Presents the stored word q and its bitwise complement q1, matching the register's q/q1 output pair.
- Sequences which requester's data is loaded each clock.

Parameters:
- N, 4, number of requesters; 2..2**IDW.
- W, 32, data width.
- IDW, 2, owner-id width.
- MAX_LOCK, 16, maximum LOCKED cycles; used only with ARB_LOCK_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  write request per requester; held until granted.
- lock  input  N  request ownership beyond this grant; meaningful only with req.
- wdata  input  N*W  packed write data; requester i at bits [i*W +: W].
- gnt  output  N  registered one-hot; high for exactly the cycle after the edge that wrote that requester's data.
- q  output  W  stored word.
- q1  output  W  always ~q.
- busy  output  1  high while state is LOCKED.
- owner  output  IDW  id of last granted requester.
- lock_to  output  1  one-cycle forced-release pulse; constant 0 without the macro.

Behaviour:
- Reset values (synchronous, active-high; clk is the only clock):
  - state = IDLE, q = 0, q1 = all ones, gnt = 0, busy = 0, owner = 0, rr_ptr = 0, lock_to = 0, lock_cnt = 0.
  - Reset overrides every other input on that edge, including mid-LOCKED: state returns to IDLE with no write.
- States: IDLE, LOCKED.
- IDLE, edge with any req high:
  - Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod N.
  - On that edge: q <= wdata[winner], gnt <= onehot(winner), owner <= winner, rr_ptr <= (winner+1) mod N.
  - If lock[winner]=1, state <= LOCKED, busy <= 1, lock_cnt <= 0.
- IDLE, edge with no req: gnt <= 0; q, owner and rr_ptr hold.
- Latency:
  - A request seen at edge k gives gnt and new q visible after edge k. No combinational path from req to gnt.
  - A requester drops req in the cycle after it sees its gnt if it has no further data.
- LOCKED:
  - Only req/lock of owner are considered; other requests stay pending and are ignored.
  - owner req=1: q <= wdata[owner], gnt <= onehot(owner).
  - owner req=0: gnt <= 0, q holds.
  - owner lock=0 at an edge releases ownership: state <= IDLE, busy <= 0, rr_ptr <= (owner+1) mod N. A write still occurs on that edge if owner req=1.
  - owner lock=1: stay LOCKED.
- lock without req in IDLE: ignored.
- Non-winning wdata: ignored.
- gnt: never more than one bit set.
- Wrap: rr_ptr wraps N-1 -> 0.
- Fairness: all N requesting continuously, with no lock, get grants in order 0,1,…,N-1,0.
- Simultaneous release and a pending other request: the other requester is arbitrated on the next edge (IDLE), not the release edge.
- q1 tracks q on the same edge; no intermediate invalid state.

Optional Feature:
- Macro: ARB_LOCK_TIMEOUT_EN.
- Defined:
  - lock_cnt increments each edge while LOCKED.
  - At the edge where lock_cnt == MAX_LOCK-1 and owner lock is still 1, forced release: state <= IDLE, busy <= 0, rr_ptr <= (owner+1) mod N, lock_to <= 1 for one cycle.
  - A write on that edge still occurs if owner req=1.
  - The former owner re-competes normally in IDLE.
- Undefined: no counter logic; lock_to tied 0; LOCKED may persist indefinitely.

Test Plan:
- Reset check: assert reset 2 cycles while req=4'b1111 -> q=0, q1=32'hFFFFFFFF, gnt=0, busy=0. Then deassert reset -> first grant goes to requester 0.
- Round-robin: req=4'b1111 held; wdata = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 -> gnt sequence 0001,0010,0100,1000,0001. q follows 11111111, 22222222, …; q1 = ~q each cycle.
- Pointer skip: rr_ptr=1, req=4'b1001 -> gnt=1000, q=wdata[3], rr_ptr=0. Next grant with req=4'b1001 -> 0001.
- Lock: requester 2 req+lock 3 cycles, requester 0 req held -> gnt=0100 three cycles, busy=1. Then lock[2]=0 with req[2]=1 -> final write, busy=0. The next edge grants requester 0.
- Owner idle in LOCKED: owner req=0, lock=1 for 2 cycles -> gnt=0, q unchanged, busy=1. Reset mid-LOCKED -> IDLE, q=0.
- ARB_LOCK_TIMEOUT_EN, MAX_LOCK=4: requester 1 holds req+lock -> 5 grants total (1 entry + 4 LOCKED), lock_to pulses once, busy falls. With other requesters requesting, requester 2 is granted next.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between N requesters and the shared register.
// master: requester side (req, lock, wdata); slave: arbiter side (gnt, q, q1, busy, owner, lock_to).
interface reg_write_arbiter_if #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [W-1:0]   q1;
    logic           busy;
    logic [IDW-1:0] owner;
    logic           lock_to;

    modport master (
        output req, lock, wdata,
        input  gnt, q, q1, busy, owner, lock_to
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, q1, busy, owner, lock_to
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one W-bit register, with optional
// multi-cycle ownership through lock.
// Ports: clk, reset (sync, active-high), bus (slave modport: req/lock/wdata in;
// gnt/q/q1/busy/owner/lock_to out).
// Macro ARB_LOCK_TIMEOUT_EN: force release after MAX_LOCK LOCKED cycles
// and pulse lock_to; undefined means lock_to is tied 0.
module reg_write_arbiter #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int IDW      = 2,
    parameter int MAX_LOCK = 16
) (
    input logic              clk,
    input logic              reset,
    reg_write_arbiter_if.slave bus
);
    if (N < 2 || N > 2**IDW || MAX_LOCK < 1) begin : g_bad_cfg
        $error("reg_write_arbiter: illegal parameter set");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    logic [W-1:0]   word;
    logic [N-1:0]   grant;
    logic           held;
    logic [IDW-1:0] own;
    logic [IDW-1:0] rr_ptr;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    logic [CW-1:0] lock_cnt;
    logic          to_pulse;
`endif

    logic           found;
    logic [IDW-1:0] win;
    int             idx;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (int'(id) == N - 1) ? '0 : id + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            word   <= '0;
            grant  <= '0;
            held   <= 1'b0;
            own    <= '0;
            rr_ptr <= '0;
`ifdef ARB_LOCK_TIMEOUT_EN
            lock_cnt <= '0;
            to_pulse <= 1'b0;
`endif
        end else begin
`ifdef ARB_LOCK_TIMEOUT_EN
            to_pulse <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        word   <= bus.wdata[int'(win)*W +: W];
                        grant  <= N'(1) << win;
                        own    <= win;
                        rr_ptr <= next_id(win);
                        if (bus.lock[win]) begin
                            state <= LOCKED;
                            held  <= 1'b1;
`ifdef ARB_LOCK_TIMEOUT_EN
                            lock_cnt <= '0;
`endif
                        end
                    end else begin
                        grant <= '0;
                    end
                end
                LOCKED: begin
                    // Only the owner is looked at; others wait for IDLE.
                    if (bus.req[own]) begin
                        word  <= bus.wdata[int'(own)*W +: W];
                        grant <= N'(1) << own;
                    end else begin
                        grant <= '0;
                    end
`ifdef ARB_LOCK_TIMEOUT_EN
                    lock_cnt <= lock_cnt + 1'b1;
`endif
                    if (!bus.lock[own]) begin
                        state  <= IDLE;
                        held   <= 1'b0;
                        rr_ptr <= next_id(own);
                    end
`ifdef ARB_LOCK_TIMEOUT_EN
                    else if (lock_cnt == CW'(MAX_LOCK - 1)) begin
                        state    <= IDLE;
                        held     <= 1'b0;
                        rr_ptr   <= next_id(own);
                        to_pulse <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = grant;
    assign bus.q     = word;
    assign bus.q1    = ~word;
    assign bus.busy  = held;
    assign bus.owner = own;
`ifdef ARB_LOCK_TIMEOUT_EN
    assign bus.lock_to = to_pulse;
`else
    assign bus.lock_to = 1'b0;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table plus lock sequences.
// Build with ARB_LOCK_TIMEOUT_EN defined to exercise the timeout path.
module tb_reg_write_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int ML  = 4;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    reg_write_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus ();

    reg_write_arbiter #(
        .N(N), .W(W), .IDW(IDW), .MAX_LOCK(ML)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  gnt;
        logic [31:0] q;
        logic        busy;
        logic [1:0]  owner;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] D0 = 32'h11111111;
    localparam logic [31:0] D1 = 32'h22222222;
    localparam logic [31:0] D2 = 32'h33333333;
    localparam logic [31:0] D3 = 32'h44444444;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] lk);
        reset    = r;
        bus.req  = rq;
        bus.lock = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g,
                           input logic [31:0] qv, input logic b,
                           input logic [1:0] o, input logic lt);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".q"}, bus.q, qv);
        chk({tag, ".q1"}, bus.q1, ~qv);
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".owner"}, 32'(bus.owner), 32'(o));
        chk({tag, ".lock_to"}, 32'(bus.lock_to), 32'(lt));
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.wdata = {D3, D2, D1, D0};

        //            rst req      lock     gnt      q   busy owner
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0001, D0, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0010, D1, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0100, D2, 1'b0, 2'd2});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b1000, D3, 1'b0, 2'd3});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0001, D0, 1'b0, 2'd0});
        // rr_ptr = 1: skip to 3, then wrap to 0
        tbl.push_back('{1'b0, 4'b1001, 4'b0000, 4'b1000, D3, 1'b0, 2'd3});
        tbl.push_back('{1'b0, 4'b1001, 4'b0000, 4'b0001, D0, 1'b0, 2'd0});
        // no request, then lock without request
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, D0, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0100, 4'b0000, D0, 1'b0, 2'd0});
        // requester 2 locks while 0 waits
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 4'b0100, D2, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 4'b0100, D2, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'b0101, 4'b0100, 4'b0100, D2, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 4'b0101, 4'b0000, 4'b0100, D2, 1'b0, 2'd2});
        tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0001, D0, 1'b0, 2'd0});
        // owner 1 idles while LOCKED, other requester ignored, then reset
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 4'b0010, D1, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0010, 4'b0000, D1, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0010, 4'b0000, D1, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 4'b1000, 4'b0010, 4'b0000, D1, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 4'b1000, 4'b0010, 4'b0000, 32'h0, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'b1000, D3, 1'b0, 2'd3});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, D3, 1'b0, 2'd3});

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].lock);
            chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].q,
                    tbl[i].busy, tbl[i].owner, 1'b0);
        end

        // rr_ptr = 0 here. Requester 1 takes and holds the lock.
`ifdef ARB_LOCK_TIMEOUT_EN
        step(1'b0, 4'b0110, 4'b0010);
        chk_out("to_entry", 4'b0010, D1, 1'b1, 2'd1, 1'b0);
        for (int c = 0; c < ML - 1; c++) begin
            step(1'b0, 4'b0110, 4'b0010);
            chk_out($sformatf("to_hold%0d", c), 4'b0010, D1, 1'b1, 2'd1, 1'b0);
        end
        step(1'b0, 4'b0110, 4'b0010);
        chk_out("to_fire", 4'b0010, D1, 1'b0, 2'd1, 1'b1);
        step(1'b0, 4'b0110, 4'b0010);
        chk_out("to_next", 4'b0100, D2, 1'b0, 2'd2, 1'b0);
`else
        step(1'b0, 4'b0110, 4'b0010);
        chk_out("lk_entry", 4'b0010, D1, 1'b1, 2'd1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0110, 4'b0010);
            chk_out($sformatf("lk_hold%0d", c), 4'b0010, D1, 1'b1, 2'd1, 1'b0);
        end
        step(1'b0, 4'b0100, 4'b0000);
        chk_out("lk_release", 4'b0000, D1, 1'b0, 2'd1, 1'b0);
        step(1'b0, 4'b0101, 4'b0000);
        chk_out("lk_next", 4'b0100, D2, 1'b0, 2'd2, 1'b0);
`endif
        step(1'b0, 4'b0000, 4'b0000);
        chk_out("tail", 4'b0000, D2, 1'b0, 2'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
